game_controller: RTL and testbench

- Sequences player movement for the VGA game top level.
- Owns the game state machine (IDLE/PLAY/PAUSE/OVER), a small FIFO of buffered turn requests, and the player position registers.
- Bounds-checks every move against the visible area.
- Runs in the fast clk domain; advances only on single-cycle game-tick pulses. Outputs feed the image renderer directly.

---
 rtl/game_controller.sv | 180 ++++++++++++++++++
 tb/tb_game_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Player-movement sequencer: IDLE/PLAY/PAUSE/OVER state machine, turn-request FIFO and bounds-checked position.
// Define GAME_CONTROLLER_WRAP_EN to wrap out-of-range moves around the screen instead of ending the game.
module game_controller #(
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int PLAYER_SIZE_X = 37,
  parameter int PLAYER_SIZE_Y = 42,
  parameter int STEP          = 5,
  parameter int START_X       = 320,
  parameter int START_Y       = 240,
  parameter int QUEUE_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic [3:0]  key_edge,
  output logic [3:0]  direction,
  output logic [15:0] player_x,
  output logic [15:0] player_y,
  output logic [3:0]  game_state,
  output logic [15:0] move_count,
  output logic        moved
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_PLAY  = 4'b0010,
    S_PAUSE = 4'b0100,
    S_OVER  = 4'b1000
  } state_t;

  localparam logic [3:0] DIR_R = 4'd1;
  localparam logic [3:0] DIR_D = 4'd2;
  localparam logic [3:0] DIR_U = 4'd4;
  localparam logic [3:0] DIR_L = 4'd8;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic signed [16:0] STEP_S = 17'(STEP);
  localparam logic signed [16:0] X_MAX  = 17'(H_RES - PLAYER_SIZE_X);
  localparam logic signed [16:0] Y_MAX  = 17'(V_RES - PLAYER_SIZE_Y);

  state_t          state_reg;
  logic [3:0]      fifo_reg  [QUEUE_DEPTH];
  logic [3:0]      fifo_next [QUEUE_DEPTH];
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_pop;
  logic [CW-1:0]   count_next;
  logic            moved_pend_reg;
  logic [3:0]      req;
  logic [3:0]      tail;
  logic [3:0]      new_dir;
  logic            play_cycle;
  logic            pop;
  logic            push;
  logic signed [16:0] nx;
  logic signed [16:0] ny;

  function automatic logic [3:0] reverse_dir(input logic [3:0] d);
    case (d)
      DIR_R:   return DIR_L;
      DIR_L:   return DIR_R;
      DIR_D:   return DIR_U;
      DIR_U:   return DIR_D;
      default: return 4'd0;
    endcase
  endfunction

  assign game_state = state_reg;
  assign play_cycle = (state_reg == S_PLAY) && !start;

  // Simultaneous keys resolve as R > D > L > U.
  always_comb begin
    req = 4'd0;
    if (key_edge[3])      req = DIR_R;
    else if (key_edge[2]) req = DIR_D;
    else if (key_edge[0]) req = DIR_L;
    else if (key_edge[1]) req = DIR_U;
  end

  // Tail is taken before any pop, so a lone queued entry still gates the push.
  always_comb begin
    tail = direction;
    for (int i = 0; i < QUEUE_DEPTH; i++)
      if (int'(count_reg) == i + 1) tail = fifo_reg[i];
  end

  assign pop       = play_cycle && tick && (count_reg != '0);
  assign new_dir   = pop ? fifo_reg[0] : direction;
  assign count_pop = count_reg - CW'(pop);
  assign push      = play_cycle && (req != 4'd0) && (req != tail) &&
                     (req != reverse_dir(tail)) && (int'(count_pop) < QUEUE_DEPTH);
  assign count_next = count_pop + CW'(push);

  for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_fifo
    logic [3:0] shifted;
    if (gi < QUEUE_DEPTH - 1) begin : g_mid
      assign shifted = pop ? fifo_reg[gi+1] : fifo_reg[gi];
    end else begin : g_last
      assign shifted = pop ? 4'd0 : fifo_reg[gi];
    end
    assign fifo_next[gi] = (push && int'(count_pop) == gi) ? req : shifted;
  end

  always_comb begin
    nx = $signed({1'b0, player_x});
    ny = $signed({1'b0, player_y});
    case (new_dir)
      DIR_R:   nx = nx + STEP_S;
      DIR_L:   nx = nx - STEP_S;
      DIR_D:   ny = ny + STEP_S;
      DIR_U:   ny = ny - STEP_S;
      default: ;
    endcase
  end

`ifdef GAME_CONTROLLER_WRAP_EN
  logic [15:0] wrap_x;
  logic [15:0] wrap_y;
  assign wrap_x = (nx > X_MAX) ? 16'd0 : (nx < 0) ? 16'(X_MAX) : nx[15:0];
  assign wrap_y = (ny > Y_MAX) ? 16'd0 : (ny < 0) ? 16'(Y_MAX) : ny[15:0];
`else
  logic in_range;
  assign in_range = (nx >= 0) && (nx <= X_MAX) && (ny >= 0) && (ny <= Y_MAX);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      direction      <= 4'd0;
      player_x       <= 16'(START_X);
      player_y       <= 16'(START_Y);
      move_count     <= 16'd0;
      count_reg      <= '0;
      moved_pend_reg <= 1'b0;
      moved          <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) fifo_reg[i] <= 4'd0;
    end else begin
      moved_pend_reg <= 1'b0;
      moved          <= moved_pend_reg;
      if (start) begin
        unique case (state_reg)
          S_IDLE: begin
            state_reg  <= S_PLAY;
            direction  <= 4'd0;
            player_x   <= 16'(START_X);
            player_y   <= 16'(START_Y);
            move_count <= 16'd0;
            count_reg  <= '0;
          end
          S_PLAY:  state_reg <= S_PAUSE;
          S_PAUSE: state_reg <= S_PLAY;
          default: state_reg <= S_IDLE;
        endcase
      end else if (state_reg == S_PLAY) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) fifo_reg[i] <= fifo_next[i];
        count_reg <= count_next;
        if (tick) direction <= new_dir;
        if (tick && new_dir != 4'd0) begin
`ifdef GAME_CONTROLLER_WRAP_EN
          player_x       <= wrap_x;
          player_y       <= wrap_y;
          moved_pend_reg <= 1'b1;
          if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
`else
          if (in_range) begin
            player_x       <= nx[15:0];
            player_y       <= ny[15:0];
            moved_pend_reg <= 1'b1;
            if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
          end else begin
            state_reg <= S_OVER;
            count_reg <= '0;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Randomized self-checking bench for game_controller against a queue-based behavioural model.
// Honours GAME_CONTROLLER_WRAP_EN for wrap-mode expectations.
module tb_game_controller;
  localparam int START_X = 320;
  localparam int START_Y = 240;
  localparam int STEP    = 5;
  localparam int XMAX    = 640 - 37;
  localparam int YMAX    = 480 - 42;
  localparam int QD      = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  key_edge = 4'd0;
  logic [3:0]  direction;
  logic [15:0] player_x;
  logic [15:0] player_y;
  logic [3:0]  game_state;
  logic [15:0] move_count;
  logic        moved;

  game_controller dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .key_edge(key_edge),
    .direction(direction), .player_x(player_x), .player_y(player_y),
    .game_state(game_state), .move_count(move_count), .moved(moved)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model: state held as the one-hot value it must show, directions as their output code.
  int mstate, mdir, mx, my, mcount;
  bit mmoved, mpend;
  int mq[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] k);
    if (k[3]) return 1;
    if (k[2]) return 2;
    if (k[0]) return 8;
    if (k[1]) return 4;
    return 0;
  endfunction

  function automatic int rev(input int d);
    case (d)
      1: return 8;
      8: return 1;
      2: return 4;
      4: return 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    mstate = 1; mdir = 0; mx = START_X; my = START_Y; mcount = 0;
    mmoved = 0; mpend = 0; mq.delete();
  endtask

  task automatic model_step(input bit t, input bit s, input logic [3:0] k);
    bit ok;
    int req, tl, nx, ny;
    ok = 0;
    if (s) begin
      case (mstate)
        1: begin mstate = 2; mx = START_X; my = START_Y; mdir = 0; mcount = 0; mq.delete(); end
        2: mstate = 4;
        4: mstate = 2;
        default: mstate = 1;
      endcase
    end else if (mstate == 2) begin
      req = pick(k);
      tl = (mq.size() > 0) ? mq[$] : mdir;
      if (t && mq.size() > 0) mdir = mq.pop_front();
      if (req != 0 && req != tl && req != rev(tl) && mq.size() < QD) mq.push_back(req);
      if (t && mdir != 0) begin
        nx = mx; ny = my;
        case (mdir)
          1: nx = nx + STEP;
          8: nx = nx - STEP;
          2: ny = ny + STEP;
          default: ny = ny - STEP;
        endcase
        if (nx >= 0 && nx <= XMAX && ny >= 0 && ny <= YMAX) ok = 1;
        else begin
`ifdef GAME_CONTROLLER_WRAP_EN
          if (nx > XMAX) nx = 0; else if (nx < 0) nx = XMAX;
          if (ny > YMAX) ny = 0; else if (ny < 0) ny = YMAX;
          ok = 1;
`else
          mstate = 8;
          mq.delete();
`endif
        end
        if (ok) begin
          mx = nx; my = ny;
          if (mcount < 65535) mcount++;
        end
      end
    end
    mmoved = mpend;
    mpend = ok;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("direction", direction, mdir);
      chk("player_x", player_x, mx);
      chk("player_y", player_y, my);
      chk("game_state", game_state, mstate);
      chk("move_count", move_count, mcount);
      chk("moved", moved, mmoved);
    end
  end

  task automatic cycle(input bit t, input bit s, input logic [3:0] k);
    tick = t; start = s; key_edge = k;
    @(posedge clk);
    model_step(t, s, k);
    #1;
    tick = 0; start = 0; key_edge = 4'd0;
  endtask

  task automatic do_reset();
    rst = 1; tick = 0; start = 0; key_edge = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic check_reset_literal(input string tag);
    chk({tag, "_state"}, game_state, 1);
    chk({tag, "_x"}, player_x, 320);
    chk({tag, "_y"}, player_y, 240);
    chk({tag, "_dir"}, direction, 0);
    chk({tag, "_count"}, move_count, 0);
    chk({tag, "_moved"}, moved, 0);
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    check_reset_literal("rst0");

    // Run right into the wall.
    cycle(0, 1, 4'd0);
    cycle(0, 0, 4'b1000);
    for (int i = 0; i < 56; i++) begin cycle(1, 0, 4'd0); cycle(0, 0, 4'd0); end
    chk("r56_x", player_x, 600);
    chk("r56_count", move_count, 56);
    cycle(1, 0, 4'd0);
`ifdef GAME_CONTROLLER_WRAP_EN
    chk("r57_x", player_x, 0);
    chk("r57_state", game_state, 2);
`else
    chk("r57_state", game_state, 8);
    chk("r57_x", player_x, 600);
`endif
    cycle(0, 0, 4'd0);
`ifdef GAME_CONTROLLER_WRAP_EN
    chk("r57_moved", moved, 1);
`else
    chk("r57_moved", moved, 0);
`endif

    // Run up to the top edge.
    do_reset();
    cycle(0, 1, 4'd0);
    cycle(0, 0, 4'b0010);
    for (int i = 0; i < 48; i++) begin cycle(1, 0, 4'd0); cycle(0, 0, 4'd0); end
    chk("u48_y", player_y, 0);
    cycle(1, 0, 4'd0);
`ifdef GAME_CONTROLLER_WRAP_EN
    chk("u49_y", player_y, 438);
    chk("u49_state", game_state, 2);
`else
    chk("u49_y", player_y, 0);
    chk("u49_state", game_state, 8);
`endif

    // Simultaneous D and L: D wins.
    do_reset();
    cycle(0, 1, 4'd0);
    cycle(0, 0, 4'b1000);
    cycle(1, 0, 4'd0);
    cycle(0, 0, 4'b0101);
    cycle(1, 0, 4'd0);
    chk("dl_dir", direction, 2);
    chk("dl_y", player_y, 245);
    chk("dl_x", player_x, 325);

    // Fill the FIFO: D, L queued; U dropped as full.
    do_reset();
    cycle(0, 1, 4'd0);
    cycle(0, 0, 4'b1000);
    cycle(1, 0, 4'd0);
    cycle(0, 0, 4'b0100);
    cycle(0, 0, 4'b0001);
    cycle(0, 0, 4'b0010);
    cycle(1, 0, 4'd0);
    chk("q1_dir", direction, 2);
    chk("q1_y", player_y, 245);
    cycle(1, 0, 4'd0);
    chk("q2_dir", direction, 8);
    chk("q2_x", player_x, 320);
    cycle(1, 0, 4'd0);
    chk("q3_dir", direction, 8);
    chk("q3_x", player_x, 315);

    // Pause freezes everything; resume moves again.
    do_reset();
    cycle(0, 1, 4'd0);
    cycle(0, 0, 4'b1000);
    cycle(1, 0, 4'd0);
    cycle(0, 1, 4'd0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 4'($urandom_range(0, 15)));
    chk("pause_state", game_state, 4);
    chk("pause_x", player_x, 325);
    chk("pause_y", player_y, 240);
    cycle(0, 1, 4'd0);
    cycle(1, 0, 4'd0);
    chk("resume_x", player_x, 330);
    cycle(1, 1, 4'd0);
    chk("st_state", game_state, 4);
    chk("st_x", player_x, 330);

    // Asynchronous reset right after a move.
    cycle(0, 1, 4'd0);
    cycle(1, 0, 4'd0);
    chk("pre_rst_x", player_x, 335);
    #1;
    rst = 1;
    model_reset();
    #1;
    check_reset_literal("rst_mid");
    @(posedge clk);
    #1 rst = 0;

    // Randomized play.
    cycle(0, 1, 4'd0);
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0,
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
